kmeans_assign_stage: RTL

KMEANS_ASSIGN_STAGE -- requirements
Module: kmeans_assign_stage

---
 rtl/kmeans_pkg.sv | 25 ++
 rtl/kmeans_sqdist.sv | 35 +++
 rtl/kmeans_assign_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_pkg
// Description : Shared widths and state encoding for the k-means assignment
//               stage and its squared-distance datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package kmeans_pkg;

  localparam int COORD_W = 8;            // one unsigned coordinate
  localparam int DIST_W  = 18;           // 3 * 255^2 = 195075 < 2^18
  localparam int LABEL_W = 2;            // centroid index
  localparam int ADDR_W  = 5;            // point-memory address
  localparam int POINT_W = 3 * COORD_W;  // packed {z,y,x}

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CMP  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/kmeans_sqdist.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_sqdist
// Description : Combinational squared Euclidean distance between two packed
//               {z,y,x} points of unsigned 8-bit coordinates.
// Ports       : a_i    - first point  {z,y,x}
//               b_i    - second point {z,y,x}
//               dist_o - (ax-bx)^2 + (ay-by)^2 + (az-bz)^2, exact
// Revision    : 1.0 - initial release
// ============================================================================
module kmeans_sqdist
  import kmeans_pkg::*;
(
  input  logic [POINT_W-1:0] a_i,
  input  logic [POINT_W-1:0] b_i,
  output logic [DIST_W-1:0]  dist_o
);

  logic [DIST_W-1:0] sq [3];

  for (genvar g = 0; g < 3; g++) begin : g_axis
    logic signed [COORD_W:0]  diff;
    logic signed [DIST_W-1:0] prod;
    assign diff  = $signed({1'b0, a_i[g*COORD_W +: COORD_W]})
                 - $signed({1'b0, b_i[g*COORD_W +: COORD_W]});
    // A square is at most 65025, so the product is non-negative and its
    // upper two bits are always zero.
    assign prod  = diff * diff;
    assign sq[g] = prod;
  end

  assign dist_o = sq[0] + sq[1] + sq[2];

endmodule
`default_nettype wire

// File: rtl/kmeans_assign_stage.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_assign_stage
// Description : One k-means assignment pass: for every point in an external
//               point memory, find the nearest of K latched centroids and
//               write that index back as the point's label.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - request a pass (ignored while busy)
//               cent            - K packed centroids, k at [24k+23:24k]
//               busy, done      - pass in progress / end-of-pass pulse
//               changed         - labels changed in the last pass
//               converged       - last pass changed no label
//               raddr,x,y,z,label - asynchronous point-memory read port
//               we,waddr,wlabel - point-memory label write port
// Revision    : 1.0 - initial release
// ============================================================================
module kmeans_assign_stage
  import kmeans_pkg::*;
#(
  parameter int N = 11,
  parameter int K = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [K*POINT_W-1:0] cent,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    changed,
  output logic                 converged,
  output logic [ADDR_W-1:0]    raddr,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic [COORD_W-1:0]   z,
  input  logic [LABEL_W-1:0]   label,
  output logic                 we,
  output logic [ADDR_W-1:0]    waddr,
  output logic [LABEL_W-1:0]   wlabel
);

  state_t               state_q;
  logic [K*POINT_W-1:0] cent_q;
  logic [ADDR_W-1:0]    idx_q;
  logic [LABEL_W-1:0]   k_q;
  logic [POINT_W-1:0]   pt_q;
  logic [LABEL_W-1:0]   old_q;
  logic [DIST_W-1:0]    best_d_q;
  logic [LABEL_W-1:0]   best_i_q;
  logic [ADDR_W-1:0]    changed_q;
  logic                 converged_q;
  logic                 done_q;

  logic [POINT_W-1:0]   cent_arr [K];
  logic [DIST_W-1:0]    cur_dist;

  for (genvar g = 0; g < K; g++) begin : g_cent
    assign cent_arr[g] = cent_q[g*POINT_W +: POINT_W];
  end

  kmeans_sqdist u_sqdist (
    .a_i    (pt_q),
    .b_i    (cent_arr[k_q]),
    .dist_o (cur_dist)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cent_q      <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      pt_q        <= '0;
      old_q       <= '0;
      best_d_q    <= '0;
      best_i_q    <= '0;
      changed_q   <= '0;
      converged_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cent_q    <= cent;
            idx_q     <= '0;
            changed_q <= '0;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pt_q     <= {z, y, x};
          old_q    <= label;
          k_q      <= '0;
          best_d_q <= '1;
          best_i_q <= '0;
          state_q  <= ST_CMP;
        end
        ST_CMP: begin
          // Strict compare: on a tie the earlier (lower) centroid is kept.
          if (cur_dist < best_d_q) begin
            best_d_q <= cur_dist;
            best_i_q <= k_q;
          end
          if (k_q == LABEL_W'(K - 1)) begin
            state_q <= ST_WR;
          end else begin
            k_q <= k_q + LABEL_W'(1);
          end
        end
        ST_WR: begin
          if (best_i_q != old_q) begin
            changed_q <= changed_q + ADDR_W'(1);
          end
          if (idx_q == ADDR_W'(N - 1)) begin
            state_q <= ST_FIN;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            state_q <= ST_LOAD;
          end
        end
        ST_FIN: begin
          // done is registered here, so it is seen in the first IDLE cycle.
          done_q      <= 1'b1;
          converged_q <= (changed_q == '0);
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign we        = (state_q == ST_WR);
  assign waddr     = idx_q;
  assign wlabel    = best_i_q;
  assign raddr     = idx_q;
  assign done      = done_q;
  assign changed   = changed_q;
  assign converged = converged_q;

endmodule
`default_nettype wire
